// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
package pipe_stage_skid_pkg;

  // Occupancy states: EMPTY (no entry), HALF (main only), FULL (main + skid).
  typedef enum logic [1:0] {
    PSKID_EMPTY = 2'd0,
    PSKID_HALF  = 2'd1,
    PSKID_FULL  = 2'd2
  } pskid_state_e;

  // Width of the entry counter.
  localparam int unsigned PSKID_CNT_W = 2;

  // Bubble payload for the IF/ID stage: NOP instruction in the low word.
  localparam logic [31:0] PSKID_FLUSH_IFID = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Enable-loaded register with synchronous reset to a parameterised value.
module pipe_stage_skid_reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load only when enabled so unselected inputs never reach the register.
  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and flush.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_data_o,
  output logic [PSKID_CNT_W-1:0] count_o
);

  pskid_state_e     state, state_n;
  logic             main_valid, skid_valid;
  logic             main_valid_n, skid_valid_n;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             accept, emit;

  assign accept = in_valid_i & in_ready_o;
  assign emit   = out_valid_o & out_ready_i;

  // Next-state and register-enable decode; flush overrides every handshake.
  always_comb begin
    state_n      = state;
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    main_en      = 1'b0;
    main_d       = in_data_i;
    skid_en      = 1'b0;
    if (flush_i) begin
      state_n      = PSKID_EMPTY;
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      main_en      = 1'b1;
      main_d       = FLUSH_VAL;
    end else begin
      case (state)
        PSKID_EMPTY: begin
          if (accept) begin
            main_en      = 1'b1;
            main_valid_n = 1'b1;
            state_n      = PSKID_HALF;
          end
        end
        PSKID_HALF: begin
          if (accept && emit) begin
            main_en = 1'b1;
          end else if (accept) begin
            skid_en      = 1'b1;
            skid_valid_n = 1'b1;
            state_n      = PSKID_FULL;
          end else if (emit) begin
            // Main keeps the emitted payload as its idle value.
            main_valid_n = 1'b0;
            state_n      = PSKID_EMPTY;
          end
        end
        PSKID_FULL: begin
          if (emit) begin
            main_en      = 1'b1;
            main_d       = skid_q;
            skid_valid_n = 1'b0;
            state_n      = PSKID_HALF;
          end
        end
        default: begin
          state_n      = PSKID_EMPTY;
          main_valid_n = 1'b0;
          skid_valid_n = 1'b0;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state <= PSKID_EMPTY;
    else     state <= state_n;
  end

  pipe_stage_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main_data (
    .clk(clk), .rst(rst), .en(main_en), .d(main_d), .q(main_q)
  );

  pipe_stage_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid_data (
    .clk(clk), .rst(rst), .en(skid_en), .d(in_data_i), .q(skid_q)
  );

  pipe_stage_skid_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_main_valid (
    .clk(clk), .rst(rst), .en(1'b1), .d(main_valid_n), .q(main_valid)
  );

  pipe_stage_skid_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_skid_valid (
    .clk(clk), .rst(rst), .en(1'b1), .d(skid_valid_n), .q(skid_valid)
  );

  assign out_valid_o = main_valid;
  assign out_data_o  = main_q;
  assign in_ready_o  = ~skid_valid;
  assign count_o     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
